// File: rtl/gbuff_pkg.sv
// Shared definitions for the global-buffer port arbiter: default widths,
// requester IDs and the owner-state encoding used by the grant FSM.
package gbuff_pkg;

  localparam int ADDR_BITS_DEF = 12;
  localparam int DATA_BITS_DEF = 32;
  localparam int MAX_BURST_DEF = 4;

  // Requester IDs double as bit positions in the req_*/rsp_* vectors.
  localparam int REQ_HOST  = 0;
  localparam int REQ_ARRAY = 1;

  // Owner FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  // Owner state that corresponds to a granted requester ID.
  function automatic logic [1:0] own_state(input logic id);
    return id ? ST_OWN1 : ST_OWN0;
  endfunction

  // One-hot grant vector for a requester ID.
  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/gbuff_rr_grant.sv
// Round-robin grant with bounded bursts for the two gbuff requesters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no owner; a tie goes to the requester that did not win last
// ST_OWN0 | host owns the port; cnt counts its consecutive beats
// ST_OWN1 | array owns the port; cnt counts its consecutive beats
//
// The owner keeps the port while it requests, unless the other side is
// waiting and the owner has already used MAX_BURST beats. cnt saturates
// at MAX_BURST so a lone owner can stream indefinitely.
module gbuff_rr_grant
  import gbuff_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] grant
);

  localparam int CNT_BITS = $clog2(MAX_BURST + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_BURST);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic [1:0]          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                last_q, last_d;

  logic in_own;
  logic own_id;
  logic other_id;
  logic gnt_any;
  logic gnt_id;

  assign in_own   = (state_q == ST_OWN0) || (state_q == ST_OWN1);
  assign own_id   = (state_q == ST_OWN1);
  assign other_id = ~own_id;

  // Grant decision and next owner/counter/last-owner state.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    if (!in_own) begin
      if (&req_valid) begin
        gnt_any = 1'b1;
        gnt_id  = ~last_q;
      end else if (|req_valid) begin
        gnt_any = 1'b1;
        gnt_id  = req_valid[REQ_ARRAY];
      end
    end else begin
      if (req_valid[own_id] && ((cnt_q < CNT_MAX) || !req_valid[other_id])) begin
        gnt_any = 1'b1;
        gnt_id  = own_id;
      end else if (req_valid[other_id]) begin
        gnt_any = 1'b1;
        gnt_id  = other_id;
      end
    end

    if (gnt_any) begin
      last_d = gnt_id;
      if (in_own && (gnt_id == own_id)) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end else begin
        state_d = own_state(gnt_id);
        cnt_d   = CNT_ONE;
      end
    end else begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // Grant is suppressed while reset is held so nothing reaches the BRAM.
  assign grant = (rst_n && gnt_any) ? id_onehot(gnt_id) : 2'b00;

  // Owner state, burst counter and last owner; host wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/gbuff_arbiter.sv
// Shares one negedge-sampled global-buffer BRAM port between the host/CFU
// loader (requester 0) and the PE-array path (requester 1). The grant is
// combinational so the BRAM sees the chosen request at the next negedge;
// read data is captured at the following posedge and tagged back to the
// requester that issued the read.
module gbuff_arbiter
  import gbuff_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_wr,
  input  logic [ADDR_BITS-1:0] req_addr0,
  input  logic [ADDR_BITS-1:0] req_addr1,
  input  logic [DATA_BITS-1:0] req_wdata0,
  input  logic [DATA_BITS-1:0] req_wdata1,
  output logic [1:0]           rsp_valid,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 bram_en,
  output logic                 bram_wr_en,
  output logic [ADDR_BITS-1:0] bram_index,
  output logic [DATA_BITS-1:0] bram_data_in,
  input  logic [DATA_BITS-1:0] bram_data_out
);

  logic [1:0]           grant;
  logic [1:0]           rd_grant;
  logic [1:0]           rsp_valid_q;
  logic [DATA_BITS-1:0] rsp_data_q;

  gbuff_rr_grant #(
    .MAX_BURST (MAX_BURST)
  ) u_rr_grant (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .grant     (grant)
  );

  assign req_ready = grant;
  assign rd_grant  = grant & ~req_wr;

  // Steer the granted requester onto the BRAM port; idle port drives zeros.
  always_comb begin
    bram_en      = 1'b0;
    bram_wr_en   = 1'b0;
    bram_index   = '0;
    bram_data_in = '0;
    if (grant[REQ_ARRAY]) begin
      bram_en      = 1'b1;
      bram_wr_en   = req_wr[REQ_ARRAY];
      bram_index   = req_addr1;
      bram_data_in = req_wdata1;
    end else if (grant[REQ_HOST]) begin
      bram_en      = 1'b1;
      bram_wr_en   = req_wr[REQ_HOST];
      bram_index   = req_addr0;
      bram_data_in = req_wdata0;
    end
  end

  // Response tag and data: the read issued last cycle returns this cycle;
  // holding the data in a register keeps it stable even if a back-to-back
  // read moves the BRAM output mid-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_grant;
      rsp_data_q  <= (|rd_grant) ? bram_data_out : '0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule
